crash_sequencer: RTL and testbench

- Sequences the 4-bit `crsh` drive into the crash/bang resonator.
- Collects crash requests from several game-event sources and arbitrates between them.
- Shapes each granted crash as a strike, a hold, then a stepwise decay of the drive level. The resonator rings on every change of `crsh`.
- Sits between the sound-latch decode and the resonator. Runs on the system clock and advances only on the 48 kHz sample enable.

---
 rtl/crash_seq_pkg.sv | 15 +
 rtl/crash_seq_if.sv | 27 ++
 rtl/crash_seq_sample_timer.sv | 31 +++
 rtl/crash_sequencer.sv | 131 +++++++++++++
 tb/tb_crash_sequencer.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/crash_seq_pkg.sv
// crash_sequencer shared types and default timing.
// Sample counts assume the 48 kHz enable.
package crash_seq_pkg;

  localparam int CRSH_W = 4;
  localparam int HOLD_SAMPLES_DEF = 480;
  localparam int DECAY_STEP_SAMPLES_DEF = 1200;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    DECAY = 2'd2
  } crash_state_t;

endpackage

// File: rtl/crash_seq_if.sv
// Request/level inputs and drive outputs of the crash sequencer.
// master = request side, slave = sequencer.
interface crash_seq_if #(
  parameter int NUM_REQ = 3
) ();
  import crash_seq_pkg::*;

  localparam int SW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req;
  logic [CRSH_W*NUM_REQ-1:0] req_level;
  logic [NUM_REQ-1:0]        grant;
  logic [CRSH_W-1:0]         crsh;
  logic                      busy;
  logic [SW-1:0]             active_src;

  modport master (
    output req, req_level,
    input  grant, crsh, busy, active_src
  );

  modport slave (
    input  req, req_level,
    output grant, crsh, busy, active_src
  );

endinterface

// File: rtl/crash_seq_sample_timer.sv
// Loadable down-counter stepped by the sample enable.
// done fires on the tick that expires the loaded count.
module sample_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (tick_i && cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign done_o = tick_i && (cnt_q == W'(1));

endmodule

// File: rtl/crash_sequencer.sv
// Arbitrates crash requests and shapes strike/hold/decay of crsh.
// State advances only on 48 kHz ticks; request capture runs every clk.
module crash_sequencer
  import crash_seq_pkg::*;
#(
  parameter int NUM_REQ            = 3,
  parameter int HOLD_SAMPLES       = HOLD_SAMPLES_DEF,
  parameter int DECAY_STEP_SAMPLES = DECAY_STEP_SAMPLES_DEF
) (
  input logic       clk,
  input logic       reset,
  input logic       clk_en_48KHz,
  crash_seq_if.slave bus
);

  localparam int SW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMAX = (HOLD_SAMPLES > DECAY_STEP_SAMPLES) ?
                        HOLD_SAMPLES : DECAY_STEP_SAMPLES;
  localparam int TW = $clog2(TMAX + 1);

  crash_state_t state_q, state_d;
  logic [NUM_REQ-1:0] req_q, pending_q, pending_d;
  logic [NUM_REQ-1:0] edge_v, clr, grant_q, grant_d;
  logic [CRSH_W-1:0]  lvl_q [NUM_REQ];
  logic [CRSH_W-1:0]  lvl_d [NUM_REQ];
  logic [CRSH_W-1:0]  crsh_q, crsh_d, win_lvl;
  logic [SW-1:0]      src_q, src_d, win;
  logic               any, ld, done;
  logic [TW-1:0]      ld_val;

  // New edges win over a same-cycle grant clear.
  always_comb begin
    edge_v = bus.req & ~req_q;
    pending_d = (pending_q & ~clr) | edge_v;
    lvl_d = lvl_q;
    for (int i = 0; i < NUM_REQ; i++)
      if (edge_v[i]) lvl_d[i] = bus.req_level[CRSH_W*i +: CRSH_W];
  end

  always_comb begin
    win = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (pending_q[i]) win = SW'(i);
    any = |pending_q;
    win_lvl = lvl_q[win];
  end

  sample_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .tick_i     (clk_en_48KHz),
    .load_i     (ld),
    .load_val_i (ld_val),
    .done_o     (done)
  );

  always_comb begin
    state_d = state_q;
    crsh_d  = crsh_q;
    grant_d = '0;
    src_d   = src_q;
    clr     = '0;
    ld      = 1'b0;
    ld_val  = TW'(HOLD_SAMPLES);
    if (clk_en_48KHz) begin
      unique case (state_q)
        IDLE: begin
          if (any) begin
            grant_d[win] = 1'b1;
            clr[win]     = 1'b1;
            src_d        = win;
            if (win_lvl != '0) begin
              crsh_d  = win_lvl;
              ld      = 1'b1;
              state_d = HOLD;
            end
          end
        end
        HOLD, DECAY: begin
          if (any && win_lvl > crsh_q) begin
            grant_d[win] = 1'b1;
            clr[win]     = 1'b1;
            src_d        = win;
            crsh_d       = win_lvl;
            ld           = 1'b1;
            state_d      = HOLD;
          end else if (done && state_q == HOLD) begin
            ld      = 1'b1;
            ld_val  = TW'(DECAY_STEP_SAMPLES);
            state_d = DECAY;
          end else if (done && crsh_q != '0) begin
            crsh_d = crsh_q - CRSH_W'(1);
            if (crsh_q == CRSH_W'(1)) begin
              state_d = IDLE;
            end else begin
              ld     = 1'b1;
              ld_val = TW'(DECAY_STEP_SAMPLES);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      crsh_q    <= '0;
      grant_q   <= '0;
      src_q     <= '0;
      req_q     <= '0;
      pending_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) lvl_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      crsh_q    <= crsh_d;
      grant_q   <= grant_d;
      src_q     <= src_d;
      req_q     <= bus.req;
      pending_q <= pending_d;
      for (int i = 0; i < NUM_REQ; i++) lvl_q[i] <= lvl_d[i];
    end
  end

  assign bus.grant      = grant_q;
  assign bus.crsh       = crsh_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.active_src = src_q;

endmodule

// File: tb/tb_crash_sequencer.sv
// Directed bench for crash_sequencer, HOLD=4, STEP=2, NUM_REQ=3.
// Inputs driven and outputs sampled at the falling edge.
module tb_crash_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;
  int ncmp = 0;
  int nerr = 0;

  crash_seq_if #(.NUM_REQ(3)) bus ();

  crash_sequencer #(
    .NUM_REQ(3),
    .HOLD_SAMPLES(4),
    .DECAY_STEP_SAMPLES(2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clk_en_48KHz (en),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic e);
    en = e;
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic edge_req(input int s, input logic [3:0] l);
    bus.req_level[4*s +: 4] = l;
    bus.req[s] = 1'b1;
    cyc(1'b0);
    bus.req[s] = 1'b0;
    cyc(1'b0);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (bus.busy && n < 80) begin
      cyc(1'b1);
      n++;
    end
    check(tag, 32'(bus.busy), 32'd0);
    check({tag, "_crsh"}, 32'(bus.crsh), 32'd0);
  endtask

  // Ticks until a grant appears; reports crsh just before it.
  task automatic wait_grant(output logic got, output logic [3:0] prev);
    got = 1'b0;
    prev = bus.crsh;
    for (int n = 0; n < 60; n++) begin
      prev = bus.crsh;
      cyc(1'b1);
      if (bus.grant != '0) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    logic gotg;
    logic [3:0] prv;
    logic [3:0] exp;
    bus.req = '0;
    bus.req_level = '0;
    cyc(1'b0);
    cyc(1'b1);
    check("rst_crsh", 32'(bus.crsh), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_src", 32'(bus.active_src), 32'd0);
    reset = 1'b0;
    cyc(1'b0);

    // single crash, level 3
    edge_req(0, 4'd3);
    cyc(1'b1);
    check("single_grant", 32'(bus.grant), 32'b001);
    check("single_t0", 32'(bus.crsh), 32'd3);
    check("single_busy", 32'(bus.busy), 32'd1);
    for (int k = 1; k <= 10; k++) begin
      cyc(1'b1);
      exp = (k <= 5) ? 4'd3 : (k <= 7) ? 4'd2 : (k <= 9) ? 4'd1 : 4'd0;
      check($sformatf("single_t%0d", k), 32'(bus.crsh), 32'(exp));
      check($sformatf("single_b%0d", k), 32'(bus.busy), (k < 10) ? 1 : 0);
      check($sformatf("single_g%0d", k), 32'(bus.grant), 32'd0);
    end

    // priority: sources 1 (7) and 2 (5) on the same clk
    bus.req_level = {4'd5, 4'd7, 4'd0};
    bus.req = 3'b110;
    cyc(1'b0);
    bus.req = 3'b000;
    cyc(1'b0);
    cyc(1'b1);
    check("prio_g1", 32'(bus.grant), 32'b010);
    check("prio_c7", 32'(bus.crsh), 32'd7);
    check("prio_src1", 32'(bus.active_src), 32'd1);
    wait_grant(gotg, prv);
    check("prio_seen", 32'(gotg), 32'd1);
    check("prio_g2", 32'(bus.grant), 32'b100);
    check("prio_c5", 32'(bus.crsh), 32'd5);
    check("prio_src2", 32'(bus.active_src), 32'd2);
    check("prio_wait", 32'(prv < 4'd5), 32'd1);
    drain("prio_drain");

    // preempt: src0 lvl 4 decayed to 2, src1 arrives at 9
    edge_req(0, 4'd4);
    cyc(1'b1);
    check("pre_t0", 32'(bus.crsh), 32'd4);
    for (int k = 0; k < 8; k++) cyc(1'b1);
    check("pre_c2", 32'(bus.crsh), 32'd2);
    edge_req(1, 4'd9);
    cyc(1'b1);
    check("pre_g1", 32'(bus.grant), 32'b010);
    check("pre_c9", 32'(bus.crsh), 32'd9);
    check("pre_src", 32'(bus.active_src), 32'd1);
    for (int k = 0; k < 5; k++) cyc(1'b1);
    check("pre_hold", 32'(bus.crsh), 32'd9);
    cyc(1'b1);
    check("pre_dec", 32'(bus.crsh), 32'd8);
    drain("pre_drain");

    // no preempt: src1 arrives at 2 while crsh=2
    edge_req(0, 4'd4);
    cyc(1'b1);
    for (int k = 0; k < 8; k++) cyc(1'b1);
    check("npre_c2", 32'(bus.crsh), 32'd2);
    edge_req(1, 4'd2);
    cyc(1'b1);
    check("npre_nog", 32'(bus.grant), 32'd0);
    wait_grant(gotg, prv);
    check("npre_seen", 32'(gotg), 32'd1);
    check("npre_g1", 32'(bus.grant), 32'b010);
    check("npre_c2b", 32'(bus.crsh), 32'd2);
    check("npre_wait", 32'(prv < 4'd2), 32'd1);
    drain("npre_drain");

    // zero level is granted and discarded
    edge_req(0, 4'd0);
    cyc(1'b1);
    check("zero_g0", 32'(bus.grant), 32'b001);
    check("zero_c", 32'(bus.crsh), 32'd0);
    check("zero_busy", 32'(bus.busy), 32'd0);
    cyc(1'b1);
    check("zero_clr", 32'(bus.grant), 32'd0);
    check("zero_busy2", 32'(bus.busy), 32'd0);

    // reset mid-crash with src2 pending
    edge_req(0, 4'd12);
    cyc(1'b1);
    check("rmid_c12", 32'(bus.crsh), 32'd12);
    edge_req(2, 4'd3);
    cyc(1'b1);
    check("rmid_nog", 32'(bus.grant), 32'd0);
    check("rmid_hold", 32'(bus.crsh), 32'd12);
    reset = 1'b1;
    cyc(1'b0);
    check("rmid_crsh", 32'(bus.crsh), 32'd0);
    check("rmid_busy", 32'(bus.busy), 32'd0);
    check("rmid_grant", 32'(bus.grant), 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1);
      check($sformatf("rpost_g%0d", k), 32'(bus.grant), 32'd0);
      check($sformatf("rpost_b%0d", k), 32'(bus.busy), 32'd0);
    end

    // enable held low for 100 clk
    bus.req_level[3:0] = 4'd6;
    bus.req[0] = 1'b1;
    for (int k = 0; k < 100; k++) begin
      cyc(1'b0);
      if (k == 1) bus.req[0] = 1'b0;
      check($sformatf("gate_g%0d", k), 32'(bus.grant), 32'd0);
      check($sformatf("gate_c%0d", k), 32'(bus.crsh), 32'd0);
    end
    cyc(1'b1);
    check("gate_grant", 32'(bus.grant), 32'b001);
    check("gate_c6", 32'(bus.crsh), 32'd6);
    drain("gate_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
